// File: rtl/result_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | result_display_ctrl: signed result -> BCD digits, blank/minus/error flags   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module result_display_ctrl #(
    parameter int DATA_W = 8,
    parameter int NDIG   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_W-1:0]   result,
    input  logic                err,
    output logic [4*NDIG-1:0]   dig_code,
    output logic [NDIG-1:0]     dig_blank,
    output logic                minus,
    output logic                err_out,
    output logic                busy,
    output logic                done
);

    localparam int SR_W  = 4*NDIG + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    generate
        if (DATA_W < 2 || NDIG < 1) begin : g_param_check
            $error("result_display_ctrl: DATA_W must be >= 2 and NDIG >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ABS    = 2'd1,
        S_CONV   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   result_q;
    logic                err_q;
    logic                sign_q;
    logic [SR_W-1:0]     sr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [4*NDIG-1:0]   dig_code_q;
    logic [NDIG-1:0]     dig_blank_q;
    logic                minus_q;
    logic                err_out_q;
    logic                busy_q;
    logic                done_q;

    logic [DATA_W-1:0]   mag_d;
    logic [SR_W-1:0]     sr_d;
    logic [SR_W-1:0]     sr_adj;
    logic [4*NDIG-1:0]   code_d;
    logic [NDIG-1:0]     blank_d;
    logic                seen_nz;

    // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1)
    // which still fits as an unsigned DATA_W-bit number.
    assign mag_d = sign_q ? (~result_q + 1'b1) : result_q;

    // One double-dabble iteration: correct every BCD nibble, then shift.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < NDIG; i++) begin
            if (sr_q[DATA_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[DATA_W + 4*i +: 4] = sr_q[DATA_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_d = sr_adj << 1;
    end

    assign code_d = sr_q[SR_W-1 -: 4*NDIG];

    // Blank every digit above the most significant nonzero one; digit 0 always shows.
    always_comb begin
        seen_nz = 1'b0;
        blank_d = '0;
        for (int i = NDIG-1; i >= 1; i--) begin
            if (code_d[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            blank_d[i] = ~seen_nz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            err_q       <= 1'b0;
            sign_q      <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
            dig_code_q  <= '0;
            dig_blank_q <= {{(NDIG-1){1'b1}}, 1'b0};
            minus_q     <= 1'b0;
            err_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        result_q <= result;
                        err_q    <= err;
                        sign_q   <= result[DATA_W-1];
                        busy_q   <= 1'b1;
                        state_q  <= S_ABS;
                    end
                end
                S_ABS: begin
                    sr_q    <= {{(4*NDIG){1'b0}}, mag_d};
                    cnt_q   <= '0;
                    state_q <= S_CONV;
                end
                S_CONV: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (err_q) begin
                        dig_code_q  <= '0;
                        dig_blank_q <= '1;
                        minus_q     <= 1'b0;
                        err_out_q   <= 1'b1;
                    end else begin
                        dig_code_q  <= code_d;
                        dig_blank_q <= blank_d;
                        minus_q     <= sign_q;
                        err_out_q   <= 1'b0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dig_code  = dig_code_q;
    assign dig_blank = dig_blank_q;
    assign minus     = minus_q;
    assign err_out   = err_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_result_display_ctrl.sv
`default_nettype none
// Testbench for result_display_ctrl: directed loads, expected commits queued
// and checked by an independent monitor on every done pulse.
module tb_result_display_ctrl;

    localparam int DATA_W = 8;
    localparam int NDIG   = 3;
    localparam int LAT    = DATA_W + 2;

    logic              clk;
    logic              rst;
    logic              load;
    logic [DATA_W-1:0] result;
    logic              err;
    logic [4*NDIG-1:0] dig_code;
    logic [NDIG-1:0]   dig_blank;
    logic              minus;
    logic              err_out;
    logic              busy;
    logic              done;

    result_display_ctrl #(.DATA_W(DATA_W), .NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .result    (result),
        .err       (err),
        .dig_code  (dig_code),
        .dig_blank (dig_blank),
        .minus     (minus),
        .err_out   (err_out),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [11:0] code;
        logic [2:0]  blank;
        logic        minus;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic done_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            tests++;
            if (done_prev) begin
                fails++;
                $display("FAIL done_width: done=1 on two consecutive cycles, required one-cycle pulse");
            end
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                tests++;
                if ({dig_code, dig_blank, minus, err_out} !== {e.code, e.blank, e.minus, e.err}) begin
                    fails++;
                    $display("FAIL commit_value: got code=%03h blank=%b minus=%b err=%b, required code=%03h blank=%b minus=%b err=%b",
                             dig_code, dig_blank, minus, err_out, e.code, e.blank, e.minus, e.err);
                end
                tests++;
                if (cyc !== e.cyc) begin
                    fails++;
                    $display("FAIL commit_latency: got cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
        done_prev = rst ? 1'b0 : done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst_outputs(input string name);
        chk({name, "_code"},  32'(dig_code),  32'h000);
        chk({name, "_blank"}, 32'(dig_blank), 32'b110);
        chk({name, "_flags"}, {28'd0, minus, err_out, busy, done}, 32'd0);
    endtask

    // Pulses load for one accepting edge, then scrambles the inputs.
    task automatic do_load(input logic [7:0] v, input logic e, input logic push,
                           input logic [11:0] c, input logic [2:0] b,
                           input logic m, input logic eo);
        exp_t x;
        @(negedge clk);
        load   = 1'b1;
        result = v;
        err    = e;
        @(posedge clk);
        #1;
        load   = 1'b0;
        result = 8'($urandom);
        err    = 1'($urandom);
        if (push) begin
            x.code  = c;
            x.blank = b;
            x.minus = m;
            x.err   = eo;
            x.cyc   = 32'(cyc + LAT);
            sb.push_back(x);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 30);
        chk({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        load   = 1'b0;
        result = '0;
        err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_rst_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero, with busy duration measured.
        do_load(8'd0, 1'b0, 1'b1, 12'h000, 3'b110, 1'b0, 1'b0);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'd10);
        @(negedge clk);
        chk("done_cleared", 32'(done), 32'd0);

        do_load(8'd127, 1'b0, 1'b1, 12'h127, 3'b000, 1'b0, 1'b0);
        wait_done("v127");
        do_load(8'd42, 1'b0, 1'b1, 12'h042, 3'b100, 1'b0, 1'b0);
        wait_done("v42");
        do_load(8'hFB, 1'b0, 1'b1, 12'h005, 3'b110, 1'b1, 1'b0);
        wait_done("vm5");
        do_load(8'h80, 1'b0, 1'b1, 12'h128, 3'b000, 1'b1, 1'b0);
        wait_done("vm128");
        do_load(8'd55, 1'b1, 1'b1, 12'h000, 3'b111, 1'b0, 1'b1);
        wait_done("err55");
        do_load(8'd9, 1'b0, 1'b1, 12'h009, 3'b110, 1'b0, 1'b0);
        wait_done("v9");

        // Load during conversion is ignored; display holds the prior commit.
        do_load(8'd127, 1'b0, 1'b1, 12'h127, 3'b000, 1'b0, 1'b0);
        wait_done("hold_pre");
        do_load(8'd3, 1'b0, 1'b1, 12'h003, 3'b110, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        load   = 1'b1;
        result = 8'd99;
        @(posedge clk);
        #1;
        load   = 1'b0;
        chk("hold_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_code", 32'(dig_code), 32'h127);
        end
        wait_done("hold_post");
        repeat (15) @(negedge clk);
        chk("no_second_commit", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-conversion.
        do_load(8'd88, 1'b0, 1'b0, 12'h000, 3'b000, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_rst_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk_rst_outputs("after_reset");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_display_ctrl.md
# result_display_ctrl

Sequencing controller between the calculator's result register and the per-digit 7-segment decoders. It captures a signed two's-complement result and converts its magnitude to BCD with a multi-cycle shift-add-3 (double-dabble) engine. It then commits one 4-bit code per digit together with leading-zero blank flags, a minus flag and an error flag. Display outputs hold the previous value until commit, so the HEX digits never show partial conversions.

## Interface
- DATA_W, 8: width of the signed result input (≥ 2)
- NDIG, 3: number of magnitude digits; must satisfy 10^NDIG > 2^(DATA_W-1)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  request to capture `result` and `err`; honoured only in IDLE
- result  input  DATA_W  signed two's-complement value to display
- err  input  1  error condition (e.g. divide by zero), sampled with `load`
- dig_code  output  4*NDIG  BCD digit codes to the decoders, digit 0 = LSD in bits [3:0]
- dig_blank  output  NDIG  1 = digit segments forced off downstream
- minus  output  1  drive minus sign on the sign digit
- err_out  output  1  error display active
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse on commit

## Operation
- FSM states: IDLE, ABS, CONV, COMMIT.
- IDLE: on `load`=1, latch `result`, `err` and sign bit `result[DATA_W-1]`; busy←1; go to ABS. With load=0, remain in IDLE.
- ABS: magnitude = sign ? (~result + 1) : result, computed as DATA_W-bit unsigned. -2^(DATA_W-1) yields 2^(DATA_W-1) with no overflow. Load the shift register as {4*NDIG zeros, magnitude}; clear the iteration counter; go to CONV.
- CONV: exactly DATA_W iterations, one per cycle.
  - Each iteration first adds 3 to every BCD nibble ≥ 5.
  - It then shifts the whole register left by 1.
  - After the DATA_W-th iteration, go to COMMIT.
- COMMIT: register the outputs; done←1 for this cycle only; busy←0; go to IDLE.
- Output rules at commit, normal case:
  - dig_code = BCD nibbles.
  - dig_blank[i]=1 for every digit above the most significant nonzero digit. dig_blank[0] is always 0, so a value of 0 shows "0".
  - minus = latched sign.
  - err_out = 0.
- Output rules at commit, latched err=1:
  - dig_blank = all ones, minus=0, err_out=1.
  - dig_code = 0.
  - Conversion latency is unchanged.
- `load` outside IDLE is ignored; it is neither queued nor restarted.
- `result` and `err` are sampled only at the accepting edge. Later changes have no effect.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-conversion):
  - state=IDLE, busy=0, done=0.
  - dig_code=0, dig_blank={NDIG-1 ones, 0}, so the display shows "0".
  - minus=0, err_out=0. Any in-flight conversion is discarded.
- Accepting edge E0 (IDLE, load=1): busy=1 after E0.
- ABS completes at E0+1. CONV occupies edges E0+2 .. E0+DATA_W+1.
- COMMIT edge: E0+DATA_W+2, which is 10 cycles for DATA_W=8. At this edge:
  - All display outputs update together.
  - done=1 for exactly one cycle.
  - busy=0.
- Next `load` is accepted at E0+DATA_W+3 at the earliest. Back-to-back loads therefore give one conversion per DATA_W+3 cycles.
- Between commits, the display outputs are stable and hold the last committed value.

## Test plan
- Reset, then result=8'd0 load → at E0+10: dig_code=0x000, dig_blank=3'b110, minus=0, done pulse 1 cycle, busy high for 10 cycles.
- result=8'd127 → dig_code=0x127, dig_blank=3'b000, minus=0. result=8'd42 → 0x042, dig_blank=3'b100.
- result=8'hFB (-5) → dig_code=0x005, dig_blank=3'b110, minus=1. result=8'h80 (-128) → 0x128, dig_blank=3'b000, minus=1.
- load with err=1, result=8'd55 → at E0+10: err_out=1, dig_blank=3'b111, minus=0. A following load of 8'd9 with err=0 → err_out=0, dig_code=0x009, dig_blank=3'b110.
- Commit 8'd127 first. Then load 8'd3, and pulse load with 8'd99 at E0+4 → 8'd99 ignored; commit shows 0x003. The outputs hold 0x127 until the commit edge.
- Assert rst at E0+5 of a 8'd88 conversion → outputs return immediately to reset values. After release: no done pulse, busy=0, display remains "0".
